// File: rtl/security_pkg.sv
// rtl/security_pkg.sv - shared security level constants and state type
package security_pkg;

    typedef logic [1:0] level_t;

    localparam level_t LVL_NONE  = 2'd0;
    localparam level_t LVL_WARN  = 2'd1;
    localparam level_t LVL_ALERT = 2'd2;
    localparam level_t LVL_LOCK  = 2'd3;

    // Enforced state shares the level encoding so it can be exported directly.
    typedef enum logic [1:0] {
        S_IDLE  = LVL_NONE,
        S_WARN  = LVL_WARN,
        S_ALERT = LVL_ALERT,
        S_LOCK  = LVL_LOCK
    } state_t;

endpackage

// File: rtl/blink_divider.sv
// rtl/blink_divider.sv - square-wave phase generator restartable on state entry
module blink_divider #(
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase
);

    localparam int unsigned CNT_W = $clog2(HALF_PERIOD) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;

    // A restart begins with the lit half so the new state is visible at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/security_response_unit.sv
// rtl/security_response_unit.sv - maps security level to LED, buzzer and door lock
module security_response_unit
    import security_pkg::*;
#(
    parameter int unsigned CLOCK_RATE    = 100_000_000,
    parameter int unsigned HOLD_SEC      = 5,
    parameter int unsigned BLINK_SLOW_HZ = 1,
    parameter int unsigned BLINK_FAST_HZ = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  level_t security_level,
    input  logic   ack,
    output logic   alarm_led,
    output logic   buzzer,
    output logic   door_lock,
    output level_t active_level
);

    localparam int unsigned HOLD_CYC  = CLOCK_RATE * HOLD_SEC;
    localparam int unsigned HOLD_W    = $clog2(HOLD_CYC) + 1;
    localparam int unsigned SLOW_HALF = CLOCK_RATE / (2 * BLINK_SLOW_HZ);
    localparam int unsigned FAST_HALF = CLOCK_RATE / (2 * BLINK_FAST_HZ);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    level_t            level_prev_q;
    logic              silenced_q, silenced_d;
    logic              state_entry;
    logic              slow_phase, fast_phase;

    always_comb begin
        state_d    = state_q;
        hold_d     = '0;
        hold_inc   = '0;
        silenced_d = silenced_q;
        if (security_level > level_t'(state_q)) begin
            state_d = state_t'(security_level);
        end else begin
            case (state_q)
                S_WARN, S_ALERT: begin
                    // A new lower value restarts the hold window with this cycle counted.
                    if (security_level < level_t'(state_q)) begin
                        hold_inc = (security_level == level_prev_q) ? hold_q + HOLD_W'(1) : HOLD_W'(1);
                        if (hold_inc == HOLD_W'(HOLD_CYC))
                            state_d = state_t'(security_level);
                        else
                            hold_d = hold_inc;
                    end
                end
                S_LOCK: begin
                    if (ack && security_level != LVL_LOCK)
                        state_d = state_t'(security_level);
                end
                default: ;
            endcase
        end
        state_entry = (state_d != state_q);
        if (state_entry)
            silenced_d = 1'b0;
        else if (state_q == S_ALERT && ack)
            silenced_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            level_prev_q <= LVL_NONE;
            silenced_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            level_prev_q <= security_level;
            silenced_q   <= silenced_d;
        end
    end

    blink_divider #(.HALF_PERIOD(SLOW_HALF)) u_slow (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_entry),
        .phase (slow_phase)
    );

    blink_divider #(.HALF_PERIOD(FAST_HALF)) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_entry),
        .phase (fast_phase)
    );

    always_comb begin
        alarm_led = 1'b0;
        buzzer    = 1'b0;
        door_lock = 1'b0;
        case (state_q)
            S_WARN:  alarm_led = slow_phase;
            S_ALERT: begin
                alarm_led = fast_phase;
                buzzer    = fast_phase & ~silenced_q;
            end
            S_LOCK: begin
                alarm_led = 1'b1;
                buzzer    = 1'b1;
                door_lock = 1'b1;
            end
            default: ;
        endcase
    end

    assign active_level = level_t'(state_q);

endmodule

// File: tb/tb_security_response_unit.sv
// tb/tb_security_response_unit.sv - self-checking bench for security_response_unit
module tb_security_response_unit;

    localparam int CLOCK_RATE = 80;
    localparam int HOLD_SEC   = 2;
    localparam int HOLD_CYC   = CLOCK_RATE * HOLD_SEC;
    localparam int SLOW_HALF  = CLOCK_RATE / 2;
    localparam int FAST_HALF  = CLOCK_RATE / 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] security_level;
    logic       ack;
    logic       alarm_led, buzzer, door_lock;
    logic [1:0] active_level;
    logic [4:0] dut_out;

    int checks = 0;
    int errors = 0;

    int m_state, m_streak, m_last_lvl, m_k;
    bit m_sil;

    typedef struct {
        logic [1:0] lvl;
        logic       a;
        int         n;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    security_response_unit #(
        .CLOCK_RATE    (CLOCK_RATE),
        .HOLD_SEC      (HOLD_SEC),
        .BLINK_SLOW_HZ (1),
        .BLINK_FAST_HZ (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .security_level (security_level),
        .ack            (ack),
        .alarm_led      (alarm_led),
        .buzzer         (buzzer),
        .door_lock      (door_lock),
        .active_level   (active_level)
    );

    assign dut_out = {active_level, alarm_led, buzzer, door_lock};

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got lvl/led/buz/lock=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_streak = 0; m_last_lvl = 0; m_k = 0; m_sil = 0;
    endtask

    // Rules: climb at once, drop after HOLD_CYC identical lower samples, lockdown needs ack.
    task automatic model_step(input int lvl, input bit a);
        int nxt;
        nxt = m_state;
        m_streak   = (lvl == m_last_lvl) ? m_streak + 1 : 1;
        m_last_lvl = lvl;
        if (lvl > m_state)
            nxt = lvl;
        else if (m_state == 3) begin
            if (a && lvl < 3) nxt = lvl;
        end else if (m_state > 0 && lvl < m_state && m_streak >= HOLD_CYC)
            nxt = lvl;
        if (nxt != m_state) begin
            m_state = nxt; m_k = 0; m_sil = 0;
        end else begin
            m_k++;
            if (m_state == 2 && a) m_sil = 1;
        end
    endtask

    function automatic logic [4:0] model_out();
        bit slow, fast;
        logic [1:0] lv;
        slow = ((m_k / SLOW_HALF) % 2) == 0;
        fast = ((m_k / FAST_HALF) % 2) == 0;
        lv   = 2'(m_state);
        case (m_state)
            1:       return {lv, slow, 1'b0, 1'b0};
            2:       return {lv, fast, fast & ~m_sil, 1'b0};
            3:       return {lv, 3'b111};
            default: return 5'b00000;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step(int'(security_level), ack);
            #1;
            check("model", dut_out, model_out());
        end
    endtask

    initial begin
        rst_n = 1'b0; security_level = 2'd0; ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset state", dut_out, 5'b00000);
        rst_n = 1'b1;

        vecs.push_back('{2'd2, 1'b0, 1,    5'b10110});
        vecs.push_back('{2'd2, 1'b0, 9,    5'b10110});
        vecs.push_back('{2'd2, 1'b0, 1,    5'b10000});
        vecs.push_back('{2'd1, 1'b0, 159,  5'b10110});
        vecs.push_back('{2'd2, 1'b0, 1,    5'b10000});
        vecs.push_back('{2'd1, 1'b0, 159,  5'b10110});
        vecs.push_back('{2'd1, 1'b0, 1,    5'b01100});
        vecs.push_back('{2'd1, 1'b0, 39,   5'b01100});
        vecs.push_back('{2'd1, 1'b0, 1,    5'b01000});
        vecs.push_back('{2'd2, 1'b0, 1,    5'b10110});
        vecs.push_back('{2'd2, 1'b1, 1,    5'b10100});
        vecs.push_back('{2'd2, 1'b0, 9,    5'b10000});
        vecs.push_back('{2'd2, 1'b0, 10,   5'b10100});
        vecs.push_back('{2'd3, 1'b0, 1,    5'b11111});
        vecs.push_back('{2'd0, 1'b0, 1000, 5'b11111});
        vecs.push_back('{2'd3, 1'b1, 1,    5'b11111});
        vecs.push_back('{2'd0, 1'b1, 1,    5'b00000});
        vecs.push_back('{2'd0, 1'b1, 3,    5'b00000});
        vecs.push_back('{2'd1, 1'b0, 1,    5'b01100});
        vecs.push_back('{2'd1, 1'b1, 1,    5'b01100});
        vecs.push_back('{2'd2, 1'b0, 1,    5'b10110});
        vecs.push_back('{2'd3, 1'b1, 1,    5'b11111});
        vecs.push_back('{2'd2, 1'b1, 1,    5'b10110});
        vecs.push_back('{2'd0, 1'b0, 159,  5'b10000});
        vecs.push_back('{2'd0, 1'b0, 1,    5'b00000});
        vecs.push_back('{2'd1, 1'b0, 1,    5'b01100});
        vecs.push_back('{2'd0, 1'b0, 160,  5'b00000});

        @(posedge clk); #1;
        model_step(0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            security_level = vecs[i].lvl;
            ack            = vecs[i].a;
            tick(vecs[i].n);
            check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
        end
        ack = 1'b0;

        // Reset asserted mid-cycle while ALERT is active.
        security_level = 2'd2;
        tick(1);
        check("alert before reset", dut_out, 5'b10110);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset", dut_out, 5'b00000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        security_level = 2'd0;
        tick(1);
        check("idle after reset", dut_out, 5'b00000);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) security_level = 2'($urandom_range(0, 3));
            ack = ($urandom_range(0, 29) == 0);
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/security_response_unit.md
Name: security_response_unit

Overview:
- Consumer end of the 2-bit security_level interface produced by the security hazard controller.
- Turns the level into physical responses: status LED blink pattern, buzzer, door lock.
- Escalation is immediate. De-escalation is filtered by a hold timer. LOCKDOWN is sticky until operator acknowledge.
- Sits between the hazard controller and board I/O (LED, buzzer driver, lock relay).

Parameters:
- CLOCK_RATE, 100_000_000, clk frequency in Hz.
- HOLD_SEC, 5, seconds a lower input level must persist before stepping down.
- BLINK_SLOW_HZ, 1, LED blink rate in WARN.
- BLINK_FAST_HZ, 4, LED blink and buzzer beep rate in ALERT.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- security_level  input  2  level from the hazard controller; 0 = none … 3 = critical.
- ack  input  1  operator acknowledge; one-cycle pulse, already synchronised and debounced.
- alarm_led  output  1  status LED.
- buzzer  output  1  buzzer enable.
- door_lock  output  1  lock relay; 1 = locked.
- active_level  output  2  level currently being enforced (= state encoding).

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0, all regs clear immediately:
  - state=IDLE; alarm_led, buzzer, door_lock, active_level = 0.
  - silenced=0; hold and blink counters = 0.
- States and encoding: IDLE=0, WARN=1, ALERT=2, LOCKDOWN=3. active_level = state.
- All outputs are registered. Input sampled at edge N → new state and outputs are visible after edge N.
- Escalation: security_level > state → state = security_level at the same edge. Hold counter and blink counter clear.
- De-escalation, from WARN or ALERT:
  - While security_level < state, the hold counter increments every cycle.
  - Hold counter clears whenever security_level changes value or becomes >= state.
  - When the count reaches HOLD_CYC = CLOCK_RATE*HOLD_SEC, state = security_level on that edge. This is a direct jump (e.g. ALERT→IDLE).
- LOCKDOWN exit: only when ack=1 and security_level<3 in the same cycle; then state = security_level, with no hold. Otherwise LOCKDOWN persists indefinitely.
- Silence:
  - ack in ALERT sets silenced=1, which forces buzzer=0.
  - silenced clears on any state change.
  - ack in IDLE or WARN is ignored.
- Simultaneous events:
  - Escalation beats ack: state escalates and silenced stays 0.
  - Escalation beats hold expiry.
- Blink generation:
  - Half-period counts are CLOCK_RATE/(2*BLINK_SLOW_HZ) and CLOCK_RATE/(2*BLINK_FAST_HZ), integer division.
  - On every state entry, the counter clears and phase=1.
  - Phase toggles when the counter reaches half-period−1, then the counter wraps to 0.
- Outputs per state:
  - IDLE: led=0, buzzer=0, lock=0.
  - WARN: led=slow phase, buzzer=0, lock=0.
  - ALERT: led=fast phase, buzzer = fast phase & ~silenced, lock=0.
  - LOCKDOWN: led=1, buzzer=1 (ack cannot silence), lock=1.
- Widths: each counter is $clog2(its limit)+1 bits. No counter wraps except the blink counter at its half-period.

Decomposition:
- Package security_pkg holds the shared constants, also used by the hazard controller: state/level constants LVL_NONE/LVL_WARN/LVL_ALERT/LVL_LOCK and the 2-bit level type.
- Sub-module blink_divider #(HALF_PERIOD):
  - ports: clk, rst_n, clear, phase.
  - Two instances: slow and fast.
  - clear is driven on state entry.

Test Plan (CLOCK_RATE=80, HOLD_SEC=2 → HOLD_CYC=160, slow half=40, fast half=10):
- Reset mid-ALERT: rst_n=0 asynchronously → all outputs 0 before the next edge; after release, state IDLE.
- Escalation: level 0→2 → after the next edge active_level=2, led=1, buzzer=1. Both toggle every 10 cycles.
- De-escalation hold: ALERT, then level=1 for 159 cycles and level=2 for 1 cycle → stays ALERT. Level=1 then held for 160 cycles → WARN, led toggles every 40 cycles.
- Silence: ALERT + ack → buzzer=0 while led keeps blinking. Level 3 then arrives → LOCKDOWN, buzzer=1, lock=1.
- LOCKDOWN stickiness: level drops to 0 for 1000 cycles → still LOCKDOWN. ack with level=3 → no change. ack with level=0 → IDLE, lock=0 after the next edge.
- Simultaneous: ALERT with ack and level=3 in the same cycle → LOCKDOWN, buzzer=1, silenced=0.
